// File: rtl/op_encode_pkg.sv
// Shared 6502 encoder definitions: mnemonics, addressing modes, error codes, FSM states.
package op_encode_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [5:0] {
      M_ADC, M_AND, M_ASL, M_BCC, M_BCS, M_BEQ, M_BIT, M_BMI,
      M_BNE, M_BPL, M_BRK, M_BVC, M_BVS, M_CLC, M_CLD, M_CLI,
      M_CLV, M_CMP, M_CPX, M_CPY, M_DEC, M_DEX, M_DEY, M_EOR,
      M_INC, M_INX, M_INY, M_JMP, M_JSR, M_LDA, M_LDX, M_LDY,
      M_LSR, M_NOP, M_ORA, M_PHA, M_PHP, M_PLA, M_PLP, M_ROL,
      M_ROR, M_RTI, M_RTS, M_SBC, M_SEC, M_SED, M_SEI, M_STA,
      M_STX, M_STY, M_TAX, M_TAY, M_TSX, M_TXA, M_TXS, M_TYA
   } mnem_t;

   typedef enum logic [3:0] {
      AM_IMP, AM_ACC, AM_IMM, AM_ZPG, AM_ZPX, AM_ZPY, AM_ABS,
      AM_ABX, AM_ABY, AM_IND, AM_XIN, AM_INY, AM_REL
   } mode_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_ILLEGAL = 2'd1,
      ERR_RANGE   = 2'd2,
      ERR_ZPOVF   = 2'd3
   } err_code_t;

   typedef enum logic [1:0] {
      ST_IDLE, ST_OP, ST_LO, ST_HI
   } state_t;

   // Instruction length in bytes implied by the addressing mode.
   function automatic logic [1:0] mode_len(input mode_t m);
      case (m)
         AM_IMP, AM_ACC:                 mode_len = 2'd1;
         AM_ABS, AM_ABX, AM_ABY, AM_IND: mode_len = 2'd3;
         default:                        mode_len = 2'd2;
      endcase
   endfunction

   // Modes whose operand must fit in page zero.
   function automatic logic is_zp_mode(input mode_t m);
      is_zp_mode = (m == AM_ZPG) || (m == AM_ZPX) || (m == AM_ZPY) ||
                   (m == AM_XIN) || (m == AM_INY);
   endfunction

endpackage

// File: rtl/op_encode_enc_lut.sv
// NMOS 6502 opcode table: (mnemonic, mode) -> opcode, length, legal.
module enc_lut
   import op_encode_pkg::*;
(
   input  mnem_t       mnem,
   input  mode_t       mode,
   output logic [7:0]  opcode,
   output logic [1:0]  len,
   output logic        legal
);

   logic [7:0] alu_base, alu_sfx, rmw_base, rmw_sfx;
   logic       alu_ok, rmw_ok;

   // Column offset of the regular ALU group (ORA..SBC share one mode layout).
   always_comb begin
      alu_sfx = 8'h00;
      alu_ok  = 1'b1;
      case (mode)
         AM_XIN:  alu_sfx = 8'h01;
         AM_ZPG:  alu_sfx = 8'h05;
         AM_IMM:  alu_sfx = 8'h09;
         AM_ABS:  alu_sfx = 8'h0D;
         AM_INY:  alu_sfx = 8'h11;
         AM_ZPX:  alu_sfx = 8'h15;
         AM_ABY:  alu_sfx = 8'h19;
         AM_ABX:  alu_sfx = 8'h1D;
         default: alu_ok  = 1'b0;
      endcase
   end

   // Column offset of the read-modify-write group (shifts, INC, DEC).
   always_comb begin
      rmw_sfx = 8'h00;
      rmw_ok  = 1'b1;
      case (mode)
         AM_ACC:  rmw_sfx = 8'h0A;
         AM_ZPG:  rmw_sfx = 8'h06;
         AM_ABS:  rmw_sfx = 8'h0E;
         AM_ZPX:  rmw_sfx = 8'h16;
         AM_ABX:  rmw_sfx = 8'h1E;
         default: rmw_ok  = 1'b0;
      endcase
   end

   // Row base of the two regular groups.
   always_comb begin
      alu_base = 8'h00;
      rmw_base = 8'h00;
      case (mnem)
         M_AND: alu_base = 8'h20;
         M_EOR: alu_base = 8'h40;
         M_ADC: alu_base = 8'h60;
         M_STA: alu_base = 8'h80;
         M_LDA: alu_base = 8'hA0;
         M_CMP: alu_base = 8'hC0;
         M_SBC: alu_base = 8'hE0;
         M_ROL: rmw_base = 8'h20;
         M_LSR: rmw_base = 8'h40;
         M_ROR: rmw_base = 8'h60;
         M_DEC: rmw_base = 8'hC0;
         M_INC: rmw_base = 8'hE0;
         default: ;
      endcase
   end

   // Full lookup; irregular instructions listed explicitly.
   always_comb begin
      opcode = 8'h00;
      legal  = 1'b0;
      len    = mode_len(mode);
      case (mnem)
         M_ORA, M_AND, M_EOR, M_ADC, M_LDA, M_CMP, M_SBC: begin
            opcode = alu_base | alu_sfx;
            legal  = alu_ok;
         end
         M_STA: begin
            opcode = alu_base | alu_sfx;
            legal  = alu_ok && (mode != AM_IMM);
         end
         M_ASL, M_ROL, M_LSR, M_ROR: begin
            opcode = rmw_base | rmw_sfx;
            legal  = rmw_ok;
         end
         M_INC, M_DEC: begin
            opcode = rmw_base | rmw_sfx;
            legal  = rmw_ok && (mode != AM_ACC);
         end
         M_LDX: begin
            legal = 1'b1;
            case (mode)
               AM_IMM:  opcode = 8'hA2;
               AM_ZPG:  opcode = 8'hA6;
               AM_ABS:  opcode = 8'hAE;
               AM_ZPY:  opcode = 8'hB6;
               AM_ABY:  opcode = 8'hBE;
               default: legal  = 1'b0;
            endcase
         end
         M_LDY: begin
            legal = 1'b1;
            case (mode)
               AM_IMM:  opcode = 8'hA0;
               AM_ZPG:  opcode = 8'hA4;
               AM_ABS:  opcode = 8'hAC;
               AM_ZPX:  opcode = 8'hB4;
               AM_ABX:  opcode = 8'hBC;
               default: legal  = 1'b0;
            endcase
         end
         M_STX: begin
            legal = 1'b1;
            case (mode)
               AM_ZPG:  opcode = 8'h86;
               AM_ABS:  opcode = 8'h8E;
               AM_ZPY:  opcode = 8'h96;
               default: legal  = 1'b0;
            endcase
         end
         M_STY: begin
            legal = 1'b1;
            case (mode)
               AM_ZPG:  opcode = 8'h84;
               AM_ABS:  opcode = 8'h8C;
               AM_ZPX:  opcode = 8'h94;
               default: legal  = 1'b0;
            endcase
         end
         M_CPX, M_CPY: begin
            legal = 1'b1;
            case (mode)
               AM_IMM:  opcode = 8'hC0;
               AM_ZPG:  opcode = 8'hC4;
               AM_ABS:  opcode = 8'hCC;
               default: legal  = 1'b0;
            endcase
            if (mnem == M_CPX) opcode = opcode | 8'h20;
         end
         M_BIT: begin
            legal = 1'b1;
            case (mode)
               AM_ZPG:  opcode = 8'h24;
               AM_ABS:  opcode = 8'h2C;
               default: legal  = 1'b0;
            endcase
         end
         M_JMP: begin
            legal = 1'b1;
            case (mode)
               AM_ABS:  opcode = 8'h4C;
               AM_IND:  opcode = 8'h6C;
               default: legal  = 1'b0;
            endcase
         end
         M_JSR: begin
            opcode = 8'h20;
            legal  = (mode == AM_ABS);
         end
         M_BPL, M_BMI, M_BVC, M_BVS, M_BCC, M_BCS, M_BNE, M_BEQ: begin
            legal = (mode == AM_REL);
            case (mnem)
               M_BPL:   opcode = 8'h10;
               M_BMI:   opcode = 8'h30;
               M_BVC:   opcode = 8'h50;
               M_BVS:   opcode = 8'h70;
               M_BCC:   opcode = 8'h90;
               M_BCS:   opcode = 8'hB0;
               M_BNE:   opcode = 8'hD0;
               default: opcode = 8'hF0;
            endcase
         end
         default: begin
            legal = (mode == AM_IMP);
            case (mnem)
               M_BRK: opcode = 8'h00;
               M_PHP: opcode = 8'h08;
               M_CLC: opcode = 8'h18;
               M_PLP: opcode = 8'h28;
               M_SEC: opcode = 8'h38;
               M_RTI: opcode = 8'h40;
               M_PHA: opcode = 8'h48;
               M_CLI: opcode = 8'h58;
               M_RTS: opcode = 8'h60;
               M_PLA: opcode = 8'h68;
               M_SEI: opcode = 8'h78;
               M_DEY: opcode = 8'h88;
               M_TXA: opcode = 8'h8A;
               M_TYA: opcode = 8'h98;
               M_TXS: opcode = 8'h9A;
               M_TAY: opcode = 8'hA8;
               M_TAX: opcode = 8'hAA;
               M_CLV: opcode = 8'hB8;
               M_TSX: opcode = 8'hBA;
               M_INY: opcode = 8'hC8;
               M_DEX: opcode = 8'hCA;
               M_CLD: opcode = 8'hD8;
               M_INX: opcode = 8'hE8;
               M_NOP: opcode = 8'hEA;
               M_SED: opcode = 8'hF8;
               default: legal = 1'b0;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/op_encode.sv
// 6502 instruction encoder: accepts (mnemonic, mode, operand), emits bytes at pc.
// Build option OP_ENCODE_BRANCH_REL_EN: REL operand is an absolute target turned
// into a signed 8-bit displacement with range check; otherwise low byte verbatim.
module op_encode
   import op_encode_pkg::*;
#(
   parameter logic [15:0] RESET_ORG = 16'h0600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        org_load,
   input  logic [15:0] org_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  mnem_t       in_mnem,
   input  mode_t       in_mode,
   input  logic [15:0] in_operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_byte,
   output logic [15:0] out_addr,
   output logic        out_last,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [15:0] pc
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
   logic [BYTE_W-1:0] byte_q, byte_d, lo_q, lo_d, hi_q, hi_d;
   logic [1:0]        len_q, len_d;
   logic              valid_q, valid_d, last_q, last_d, err_q, err_d;
   err_code_t         code_q, code_d;

   logic [7:0]        lut_opcode;
   logic [1:0]        lut_len;
   logic              lut_legal;
   logic [BYTE_W-1:0] rel_lo;
   logic              rel_bad;
   logic              accept, xfer;
   logic [ADDR_W-1:0] pc_inc;

   enc_lut u_lut (
      .mnem   (in_mnem),
      .mode   (in_mode),
      .opcode (lut_opcode),
      .len    (lut_len),
      .legal  (lut_legal)
   );

   assign in_ready = (state_q == ST_IDLE) && !org_load;
   assign accept   = in_valid && in_ready;
   assign xfer     = valid_q && out_ready;
   assign pc_inc   = pc_q + 16'd1;

`ifdef OP_ENCODE_BRANCH_REL_EN
   logic [ADDR_W-1:0] rel_off;
   // Displacement from the address following the 2-byte branch.
   always_comb begin
      rel_off = in_operand - (pc_q + 16'd2);
      rel_lo  = rel_off[7:0];
      rel_bad = (rel_off[15:7] != 9'h000) && (rel_off[15:7] != 9'h1FF);
   end
`else
   // Branch operand passed through untouched.
   always_comb begin
      rel_lo  = in_operand[7:0];
      rel_bad = 1'b0;
   end
`endif

   // Next-state and output computation.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      byte_d  = byte_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      len_d   = len_q;
      valid_d = valid_q;
      last_d  = last_q;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      case (state_q)
         ST_IDLE: begin
            if (org_load) begin
               pc_d = org_addr;
            end else if (accept) begin
               if (!lut_legal) begin
                  err_d  = 1'b1;
                  code_d = ERR_ILLEGAL;
               end else if (is_zp_mode(in_mode) && (in_operand[15:8] != 8'h00)) begin
                  err_d  = 1'b1;
                  code_d = ERR_ZPOVF;
               end else if ((in_mode == AM_REL) && rel_bad) begin
                  err_d  = 1'b1;
                  code_d = ERR_RANGE;
               end else begin
                  state_d = ST_OP;
                  valid_d = 1'b1;
                  byte_d  = lut_opcode;
                  addr_d  = pc_q;
                  last_d  = (lut_len == 2'd1);
                  len_d   = lut_len;
                  lo_d    = (in_mode == AM_REL) ? rel_lo : in_operand[7:0];
                  hi_d    = in_operand[15:8];
               end
            end
         end
         ST_OP: begin
            if (xfer) begin
               pc_d = pc_inc;
               if (len_q == 2'd1) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  state_d = ST_LO;
                  byte_d  = lo_q;
                  addr_d  = pc_inc;
                  last_d  = (len_q == 2'd2);
               end
            end
         end
         ST_LO: begin
            if (xfer) begin
               pc_d = pc_inc;
               if (len_q == 2'd2) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  state_d = ST_HI;
                  byte_d  = hi_q;
                  addr_d  = pc_inc;
                  last_d  = 1'b1;
               end
            end
         end
         default: begin
            if (xfer) begin
               pc_d    = pc_inc;
               state_d = ST_IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
         end
      endcase
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_ORG;
         addr_q  <= RESET_ORG;
         byte_q  <= 8'h00;
         lo_q    <= 8'h00;
         hi_q    <= 8'h00;
         len_q   <= 2'd0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         byte_q  <= byte_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         len_q   <= len_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign out_valid = valid_q;
   assign out_byte  = byte_q;
   assign out_addr  = addr_q;
   assign out_last  = last_q;
   assign err       = err_q;
   assign err_code  = code_q;
   assign pc        = pc_q;

endmodule

// File: tb/tb_op_encode.sv
// Directed bench for op_encode: byte stream, backpressure, branches, errors, wrap, reset.
module tb_op_encode;
   import op_encode_pkg::*;

   logic        clk = 1'b0;
   logic        rst, org_load, in_valid, out_ready;
   logic [15:0] org_addr, in_operand;
   mnem_t       in_mnem;
   mode_t       in_mode;
   logic        in_ready, out_valid, out_last, err;
   logic [7:0]  out_byte;
   logic [15:0] out_addr, pc;
   logic [1:0]  err_code;

   int n_vec = 0;
   int n_bad = 0;

   op_encode #(.RESET_ORG(16'h0600)) dut (
      .clk        (clk),
      .rst        (rst),
      .org_load   (org_load),
      .org_addr   (org_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mnem    (in_mnem),
      .in_mode    (in_mode),
      .in_operand (in_operand),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_byte   (out_byte),
      .out_addr   (out_addr),
      .out_last   (out_last),
      .err        (err),
      .err_code   (err_code),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_org(input logic [15:0] a);
      org_load = 1'b1;
      org_addr = a;
      #1;
      chk("org_in_ready", 32'(in_ready), 32'd0);
      step();
      org_load = 1'b0;
      #1;
      chk("org_pc", 32'(pc), 32'(a));
   endtask

   task automatic send(input mnem_t m, input mode_t md, input logic [15:0] opnd);
      in_mnem    = m;
      in_mode    = md;
      in_operand = opnd;
      in_valid   = 1'b1;
      #1;
      chk("send_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Hold out_ready low for `stalls` cycles (optionally poking org_load), then transfer.
   task automatic take(input string tag, input logic [7:0] b, input logic [15:0] a,
                       input logic l, input int stalls, input bit poke);
      out_ready = 1'b0;
      for (int i = 0; i < stalls; i++) begin
         chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_stall_byte"},  32'(out_byte),  32'(b));
         chk({tag, "_stall_addr"},  32'(out_addr),  32'(a));
         chk({tag, "_stall_last"},  32'(out_last),  32'(l));
         if (poke) begin
            org_load = 1'b1;
            org_addr = 16'h1234;
         end
         step();
         org_load = 1'b0;
      end
      out_ready = 1'b1;
      #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_byte"},  32'(out_byte),  32'(b));
      chk({tag, "_addr"},  32'(out_addr),  32'(a));
      chk({tag, "_last"},  32'(out_last),  32'(l));
      step();
      out_ready = 1'b0;
   endtask

   task automatic idle_chk(input string tag, input logic [15:0] exp_pc);
      #1;
      chk({tag, "_valid"},    32'(out_valid), 32'd0);
      chk({tag, "_last"},     32'(out_last),  32'd0);
      chk({tag, "_pc"},       32'(pc),        32'(exp_pc));
      chk({tag, "_in_ready"}, 32'(in_ready),  32'd1);
      chk({tag, "_err"},      32'(err),       32'd0);
   endtask

   task automatic err_chk(input string tag, input logic [1:0] code, input logic [15:0] exp_pc);
      #1;
      chk({tag, "_err"},   32'(err),       32'd1);
      chk({tag, "_code"},  32'(err_code),  32'(code));
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, "_err_clr"},  32'(err),      32'd0);
      chk({tag, "_code_clr"}, 32'(err_code), 32'd0);
      idle_chk({tag, "_after"}, exp_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; org_load = 1'b0; org_addr = 16'h0000; in_valid = 1'b0;
      out_ready = 1'b0; in_mnem = M_NOP; in_mode = AM_IMP; in_operand = 16'h0000;
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_pc",       32'(pc),        32'h0600);
      chk("rst_out_addr", 32'(out_addr),  32'h0600);
      chk("rst_out_byte", 32'(out_byte),  32'h00);
      chk("rst_valid",    32'(out_valid), 32'd0);
      chk("rst_last",     32'(out_last),  32'd0);
      chk("rst_err",      32'(err),       32'd0);
      chk("rst_code",     32'(err_code),  32'd0);
      chk("rst_in_ready", 32'(in_ready),  32'd1);

      // LDA #$42
      send(M_LDA, AM_IMM, 16'h0042);
      take("lda_op", 8'hA9, 16'h0600, 1'b0, 0, 1'b0);
      take("lda_lo", 8'h42, 16'h0601, 1'b1, 0, 1'b0);
      idle_chk("lda_done", 16'h0602);

      // STA $0200,X under backpressure; org_load while busy must be ignored
      send(M_STA, AM_ABX, 16'h0200);
      take("sta_op", 8'h9D, 16'h0602, 1'b0, 2, 1'b1);
      take("sta_lo", 8'h00, 16'h0603, 1'b0, 1, 1'b0);
      take("sta_hi", 8'h02, 16'h0604, 1'b1, 3, 1'b1);
      idle_chk("sta_done", 16'h0605);

      // BNE to $0600 from $0610
      set_org(16'h0610);
      send(M_BNE, AM_REL, 16'h0600);
      take("bne_op", 8'hD0, 16'h0610, 1'b0, 0, 1'b0);
`ifdef OP_ENCODE_BRANCH_REL_EN
      take("bne_lo", 8'hEE, 16'h0611, 1'b1, 0, 1'b0);
`else
      take("bne_lo", 8'h00, 16'h0611, 1'b1, 0, 1'b0);
`endif
      idle_chk("bne_done", 16'h0612);

      // BNE to $0700 from $0610
      set_org(16'h0610);
      send(M_BNE, AM_REL, 16'h0700);
`ifdef OP_ENCODE_BRANCH_REL_EN
      err_chk("bne_range", 2'd2, 16'h0610);
`else
      take("bne_far_op", 8'hD0, 16'h0610, 1'b0, 0, 1'b0);
      take("bne_far_lo", 8'h00, 16'h0611, 1'b1, 0, 1'b0);
      idle_chk("bne_far_done", 16'h0612);
`endif

      // Illegal combination and zero-page overflow
      set_org(16'h0620);
      send(M_STA, AM_IMM, 16'h0010);
      err_chk("sta_imm", 2'd1, 16'h0620);
      send(M_LDA, AM_ZPG, 16'h0180);
      err_chk("lda_zpovf", 2'd3, 16'h0620);

      // LDX $10,Y then a one-byte ASL A
      send(M_LDX, AM_ZPY, 16'h0010);
      take("ldx_op", 8'hB6, 16'h0620, 1'b0, 0, 1'b0);
      take("ldx_lo", 8'h10, 16'h0621, 1'b1, 0, 1'b0);
      send(M_ASL, AM_ACC, 16'h0000);
      take("asl_op", 8'h0A, 16'h0622, 1'b1, 1, 1'b0);
      idle_chk("asl_done", 16'h0623);

      // pc wrap
      set_org(16'hFFFF);
      send(M_NOP, AM_IMP, 16'h0000);
      take("nop_op", 8'hEA, 16'hFFFF, 1'b1, 0, 1'b0);
      idle_chk("nop_wrap", 16'h0000);

      // reset after first byte of JMP ($1234)
      send(M_JMP, AM_IND, 16'h1234);
      take("jmp_op", 8'h6C, 16'h0000, 1'b0, 0, 1'b0);
      chk("jmp_lo_pending", 32'(out_byte), 32'h34);
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("jmp_rst_pc",    32'(pc),        32'h0600);
      chk("jmp_rst_addr",  32'(out_addr),  32'h0600);
      chk("jmp_rst_byte",  32'(out_byte),  32'h00);
      for (int i = 0; i < 3; i++) begin
         chk("jmp_rst_valid", 32'(out_valid), 32'd0);
         step();
      end
      out_ready = 1'b0;
      idle_chk("jmp_rst_idle", 16'h0600);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
